// File: rtl/pe_id_scan_loader_if.sv
// Bundles the PE-ID loader's table-write, scan-control and scan-output ports.
// The master side is the controller; the slave side is the loader.
interface pe_id_scan_loader_if #(
   parameter int NUMS_PE_ROW = 6,
   parameter int NUMS_PE_COL = 8,
   parameter int XID_BITS    = 4,
   parameter int YID_BITS    = 3,
   parameter int NUM_CH      = 4
);
   localparam int N     = NUMS_PE_ROW * NUMS_PE_COL;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = $clog2(N);
   localparam int ROW_W = $clog2(NUMS_PE_ROW);

   logic                         start;
   logic                         mode;
   logic                         hold;
   logic                         xid_we;
   logic [CH_W-1:0]              xid_ch;
   logic [IDX_W-1:0]             xid_idx;
   logic [XID_BITS-1:0]          xid_data;
   logic                         yid_we;
   logic [CH_W-1:0]              yid_ch;
   logic [ROW_W-1:0]             yid_idx;
   logic [YID_BITS-1:0]          yid_data;
   logic                         ln_we;
   logic [NUMS_PE_ROW-2:0]       ln_data;
   logic                         busy;
   logic                         done;
   logic                         wr_err;
   logic                         set_XID;
   logic [NUM_CH*XID_BITS-1:0]   XID_scan_in;
   logic                         set_YID;
   logic [NUM_CH*YID_BITS-1:0]   YID_scan_in;
   logic                         set_LN;
   logic [NUMS_PE_ROW-2:0]       LN_config_in;

   modport master (
      output start, mode, hold,
      output xid_we, xid_ch, xid_idx, xid_data,
      output yid_we, yid_ch, yid_idx, yid_data,
      output ln_we, ln_data,
      input  busy, done, wr_err,
      input  set_XID, XID_scan_in, set_YID, YID_scan_in, set_LN, LN_config_in
   );

   modport slave (
      input  start, mode, hold,
      input  xid_we, xid_ch, xid_idx, xid_data,
      input  yid_we, yid_ch, yid_idx, yid_data,
      input  ln_we, ln_data,
      output busy, done, wr_err,
      output set_XID, XID_scan_in, set_YID, YID_scan_in, set_LN, LN_config_in
   );
endinterface

// File: rtl/pe_id_scan_loader.sv
// Loads XID/YID/LN tables via write ports and shifts them into the PE array on start.
// First scan cycle follows start by one clock, done L+1 cycles after start; hold stalls the scan in place.
module pe_id_scan_loader #(
   parameter int NUMS_PE_ROW = 6,
   parameter int NUMS_PE_COL = 8,
   parameter int XID_BITS    = 4,
   parameter int YID_BITS    = 3,
   parameter int NUM_CH      = 4
) (
   input logic               clk,
   input logic               rst,
   pe_id_scan_loader_if.slave bus
);
   localparam int N     = NUMS_PE_ROW * NUMS_PE_COL;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = $clog2(N);
   localparam int ROW_W = $clog2(NUMS_PE_ROW);
   localparam int CNT_W = IDX_W;

   localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] LAST_YID  = CNT_W'(NUMS_PE_ROW - 1);
   localparam logic [CNT_W-1:0] ROW_LIM   = CNT_W'(NUMS_PE_ROW);
   localparam logic [IDX_W:0]   XIDX_LIM  = (IDX_W + 1)'(N);
   localparam logic [ROW_W:0]   YIDX_LIM  = (ROW_W + 1)'(NUMS_PE_ROW);
   localparam logic [CH_W:0]    CH_LIM    = (CH_W + 1)'(NUM_CH);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt;
   logic                   mode_q;
   logic                   wr_err_q;
   logic [XID_BITS-1:0]    xid_tbl [NUM_CH][N];
   logic [YID_BITS-1:0]    yid_tbl [NUM_CH][NUMS_PE_ROW];
   logic [NUMS_PE_ROW-2:0] ln_reg;

   logic scanning, scan_act, cnt_last, launch, yid_in, any_we;

   assign scanning = (state_q == S_SCAN);
   assign scan_act = scanning && !bus.hold;
   assign cnt_last = (cnt == (mode_q ? LAST_YID : LAST_FULL));
   assign launch   = (state_q == S_IDLE) && bus.start;
   assign yid_in   = (cnt < ROW_LIM);
   assign any_we   = bus.xid_we || bus.yid_we || bus.ln_we;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_SCAN;
         S_SCAN:  if (!bus.hold && cnt_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt      <= '0;
         mode_q   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (launch) begin
            mode_q   <= bus.mode;
            cnt      <= '0;
            wr_err_q <= 1'b0;
         end else begin
            if (scan_act) cnt <= cnt + 1'b1;
            if (scanning && any_we) wr_err_q <= 1'b1;
         end
      end
   end

   // Tables accept writes outside SCAN only; out-of-range channel or index is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < N; k++) xid_tbl[c][k] <= '0;
            for (int r = 0; r < NUMS_PE_ROW; r++) yid_tbl[c][r] <= '0;
         end
         ln_reg <= '0;
      end else if (!scanning) begin
         if (bus.xid_we && ({1'b0, bus.xid_idx} < XIDX_LIM) && ({1'b0, bus.xid_ch} < CH_LIM))
            xid_tbl[bus.xid_ch][bus.xid_idx] <= bus.xid_data;
         if (bus.yid_we && ({1'b0, bus.yid_idx} < YIDX_LIM) && ({1'b0, bus.yid_ch} < CH_LIM))
            yid_tbl[bus.yid_ch][bus.yid_idx] <= bus.yid_data;
         if (bus.ln_we)
            ln_reg <= bus.ln_data;
      end
   end

   always_comb begin
      bus.busy         = scanning;
      bus.done         = (state_q == S_DONE);
      bus.wr_err       = wr_err_q;
      bus.set_XID      = 1'b0;
      bus.set_YID      = 1'b0;
      bus.set_LN       = 1'b0;
      bus.XID_scan_in  = '0;
      bus.YID_scan_in  = '0;
      bus.LN_config_in = '0;
      if (scan_act) begin
         bus.set_XID      = !mode_q;
         bus.set_YID      = yid_in;
         bus.set_LN       = (cnt == '0);
         bus.LN_config_in = ln_reg;
         for (int c = 0; c < NUM_CH; c++) begin
            bus.XID_scan_in[c*XID_BITS +: XID_BITS] = xid_tbl[c][cnt];
            if (yid_in)
               bus.YID_scan_in[c*YID_BITS +: YID_BITS] = yid_tbl[c][cnt[ROW_W-1:0]];
         end
      end
   end
endmodule

// File: tb/tb_pe_id_scan_loader.sv
// Directed bench for pe_id_scan_loader: default 6x8x4ch instance plus a 4x4x2ch sweep instance.
module tb_pe_id_scan_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   pe_id_scan_loader_if if0();
   pe_id_scan_loader_if #(.NUMS_PE_ROW(4), .NUMS_PE_COL(4), .NUM_CH(2)) if1();

   pe_id_scan_loader u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   pe_id_scan_loader #(.NUMS_PE_ROW(4), .NUMS_PE_COL(4), .XID_BITS(4), .YID_BITS(3), .NUM_CH(2))
      u1 (.clk(clk), .rst(rst), .bus(if1.slave));

   logic [3:0] xm [4][48];
   logic [2:0] ym [4][6];
   logic [4:0] lnm;
   logic [3:0] xs [2][16];
   logic [2:0] ys [2][4];

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_x(input int k);
      logic [15:0] v;
      for (int c = 0; c < 4; c++) v[c*4 +: 4] = xm[c][k];
      return v;
   endfunction

   function automatic logic [11:0] exp_y(input int k);
      logic [11:0] v;
      v = '0;
      if (k < 6) for (int c = 0; c < 4; c++) v[c*3 +: 3] = ym[c][k];
      return v;
   endfunction

   task automatic wx(input int ch, input int idx, input int d);
      if0.xid_we = 1'b1; if0.xid_ch = 2'(ch); if0.xid_idx = 6'(idx); if0.xid_data = 4'(d);
      step();
      if0.xid_we = 1'b0;
   endtask

   task automatic wy(input int ch, input int idx, input int d);
      if0.yid_we = 1'b1; if0.yid_ch = 2'(ch); if0.yid_idx = 3'(idx); if0.yid_data = 3'(d);
      step();
      if0.yid_we = 1'b0;
   endtask

   // Pulses start, walks every scan cycle against the model, then checks the done cycle.
   task automatic scan0(input bit md, input int hold_at, input int hold_n, input int evt_at);
      int L, k;
      bit held;
      L = md ? 6 : 48;
      if0.mode = md; if0.start = 1'b1;
      step();
      if0.start = 1'b0; if0.mode = 1'b0;
      for (int t = 0; t < L + hold_n; t++) begin
         held = (t >= hold_at) && (t < hold_at + hold_n);
         k = (t < hold_at) ? t : (held ? hold_at : t - hold_n);
         if0.hold = held;
         #1;
         chk("busy_in_scan", if0.busy, 1'b1);
         chk("done_in_scan", if0.done, 1'b0);
         if (t == 0) chk("wr_err_cleared", if0.wr_err, 1'b0);
         if (held) begin
            chk("held_set", {if0.set_XID, if0.set_YID, if0.set_LN}, 3'b000);
            chk("held_xid", if0.XID_scan_in, 16'h0);
            chk("held_yid", if0.YID_scan_in, 12'h0);
         end else begin
            chk("set_xid", if0.set_XID, !md);
            chk("xid_data", if0.XID_scan_in, exp_x(k));
            chk("set_yid", if0.set_YID, k < 6);
            chk("yid_data", if0.YID_scan_in, exp_y(k));
            chk("set_ln", if0.set_LN, k == 0);
            chk("ln_data", if0.LN_config_in, lnm);
         end
         if (t == evt_at) begin
            if0.xid_we = 1'b1; if0.xid_ch = 2'd0; if0.xid_idx = 6'd0; if0.xid_data = 4'hF;
            if0.start = 1'b1;
         end
         step();
         if0.xid_we = 1'b0; if0.start = 1'b0;
      end
      if0.hold = 1'b0;
      #1;
      chk("done_pulse", if0.done, 1'b1);
      chk("busy_in_done", if0.busy, 1'b0);
      chk("sets_in_done", {if0.set_XID, if0.set_YID, if0.set_LN}, 3'b000);
   endtask

   initial begin
      rst = 1'b0;
      {if0.start, if0.mode, if0.hold, if0.xid_we, if0.yid_we, if0.ln_we} = '0;
      if0.xid_ch = '0; if0.xid_idx = '0; if0.xid_data = '0;
      if0.yid_ch = '0; if0.yid_idx = '0; if0.yid_data = '0; if0.ln_data = '0;
      {if1.start, if1.mode, if1.hold, if1.xid_we, if1.yid_we, if1.ln_we} = '0;
      if1.xid_ch = '0; if1.xid_idx = '0; if1.xid_data = '0;
      if1.yid_ch = '0; if1.yid_idx = '0; if1.yid_data = '0; if1.ln_data = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 48; k++) xm[c][k] = '0;
         for (int r = 0; r < 6; r++) ym[c][r] = '0;
      end
      lnm = '0;

      // Reset state
      #1;
      chk("rst_busy", if0.busy, 1'b0);
      chk("rst_done", if0.done, 1'b0);
      chk("rst_wr_err", if0.wr_err, 1'b0);
      chk("rst_sets", {if0.set_XID, if0.set_YID, if0.set_LN}, 3'b000);
      chk("rst_data", {if0.XID_scan_in, if0.YID_scan_in, if0.LN_config_in}, 33'h0);
      step(); step();
      rst = 1'b1;
      step();

      // Load tables and run a full scan
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 48; k++) begin
            wx(c, k, (k + c) % 16);
            xm[c][k] = 4'((k + c) % 16);
         end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 6; r++) begin
            wy(c, r, r + c);
            ym[c][r] = 3'(r + c);
         end
      if0.ln_we = 1'b1; if0.ln_data = 5'b10101;
      step();
      if0.ln_we = 1'b0; lnm = 5'b10101;
      scan0(1'b0, 1000, 0, -1);

      // start sampled in DONE is ignored
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
      #1;
      chk("start_in_done_ignored", if0.busy, 1'b0);

      // Earliest restart from the first IDLE cycle, YID-only mode
      scan0(1'b1, 1000, 0, -1);
      step();

      // Three-cycle hold at cnt=10
      scan0(1'b0, 10, 3, -1);
      step();

      // Write and start during SCAN are dropped; the write flags wr_err
      scan0(1'b0, 1000, 0, 5);
      chk("wr_err_set", if0.wr_err, 1'b1);
      step();
      wx(0, 48, 15);
      #1;
      chk("wr_err_sticky", if0.wr_err, 1'b1);
      scan0(1'b0, 1000, 0, -1);
      step();

      // Reset at cnt=20
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      #1;
      chk("pre_rst_xid", if0.XID_scan_in, exp_x(20));
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", if0.busy, 1'b0);
      chk("mid_rst_sets", {if0.set_XID, if0.set_YID, if0.set_LN}, 3'b000);
      chk("mid_rst_xid", if0.XID_scan_in, 16'h0);
      step();
      rst = 1'b1;
      step();
      #1;
      chk("no_done_after_rst", if0.done, 1'b0);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 48; k++) xm[c][k] = '0;
         for (int r = 0; r < 6; r++) ym[c][r] = '0;
      end
      lnm = '0;
      scan0(1'b0, 1000, 0, -1);
      step();

      // Parameter sweep instance: 4x4 array, 2 channels
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 16; k++) begin
            xs[c][k] = 4'((k * 3 + c * 5) % 16);
            if1.xid_we = 1'b1; if1.xid_ch = 1'(c); if1.xid_idx = 4'(k); if1.xid_data = xs[c][k];
            step();
         end
      if1.xid_we = 1'b0;
      for (int r = 0; r < 4; r++) begin
         ys[0][r] = 3'(r + 1);
         ys[1][r] = 3'(7 - r);
      end
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 4; r++) begin
            if1.yid_we = 1'b1; if1.yid_ch = 1'(c); if1.yid_idx = 2'(r); if1.yid_data = ys[c][r];
            step();
         end
      if1.yid_we = 1'b0;
      if1.ln_we = 1'b1; if1.ln_data = 3'b101;
      step();
      if1.ln_we = 1'b0;
      if1.start = 1'b1;
      step();
      if1.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("sw_set_xid", if1.set_XID, 1'b1);
         chk("sw_xid_data", if1.XID_scan_in, {xs[1][k], xs[0][k]});
         chk("sw_set_yid", if1.set_YID, k < 4);
         chk("sw_yid_data", if1.YID_scan_in, (k < 4) ? {ys[1][k & 3], ys[0][k & 3]} : 6'h0);
         chk("sw_set_ln", if1.set_LN, k == 0);
         chk("sw_ln_data", if1.LN_config_in, 3'b101);
         step();
      end
      #1;
      chk("sw_done", if1.done, 1'b1);
      chk("sw_busy", if1.busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/pe_id_scan_loader.md
# pe_id_scan_loader

Parametrised scan-chain configurator for the PE array, sitting between the controller's MMIO register file and the PE array's XID/YID/LN scan inputs. IDs are loaded at run time through write ports into internal tables, replacing fixed initial-file images. On `start`, the block shifts the tables into the array and signals `done`. It supports N routing channels, a YID/LN-only reload mode, and a stall input.

## Interface
- NUMS_PE_ROW, 6, PE rows (≥2)
- NUMS_PE_COL, 8, PE columns
- XID_BITS, 4, X tag width
- YID_BITS, 3, Y tag width
- NUM_CH, 4, routing channels (0 ifmap, 1 filter, 2 ipsum, 3 opsum; extras allowed)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a scan
- mode  in  1  sampled with start: 0 = full scan, 1 = YID/LN only
- hold  in  1  stall the scan in place
- xid_we  in  1  XID table write strobe
- xid_ch  in  $clog2(NUM_CH)  XID write channel
- xid_idx  in  $clog2(NUMS_PE_ROW*NUMS_PE_COL)  XID write PE index
- xid_data  in  XID_BITS  XID write value
- yid_we  in  1  YID table write strobe
- yid_ch  in  $clog2(NUM_CH)  YID write channel
- yid_idx  in  $clog2(NUMS_PE_ROW)  YID write row index
- yid_data  in  YID_BITS  YID write value
- ln_we  in  1  LN register write strobe
- ln_data  in  NUMS_PE_ROW-1  LN config value
- busy  out  1  high in SCAN state
- done  out  1  one-cycle completion pulse
- wr_err  out  1  sticky error: table write attempted while busy; cleared on start
- set_XID  out  1  XID scan enable
- XID_scan_in  out  NUM_CH*XID_BITS  channel c at bits [c*XID_BITS +: XID_BITS]
- set_YID  out  1  YID scan enable
- YID_scan_in  out  NUM_CH*YID_BITS  channel c at bits [c*YID_BITS +: YID_BITS]
- set_LN  out  1  LN load enable
- LN_config_in  out  NUMS_PE_ROW-1  LN value

## Operation
- Let N = NUMS_PE_ROW*NUMS_PE_COL. The scan length L = N in full mode and L = NUMS_PE_ROW in YID-only mode.
- State machine:
  - IDLE → SCAN when `start`. On this edge, latch `mode`, clear `cnt` to 0 and clear `wr_err`.
  - SCAN: `cnt` increments each cycle in which `hold`=0. It moves to DONE on the edge where `hold`=0 and `cnt`==L-1.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- SCAN outputs, with all scan outputs gated by `!hold`:
  - `set_XID` = !mode_q.
  - `set_YID` = (`cnt` < NUMS_PE_ROW).
  - `set_LN` = (`cnt`==0).
- Scan data is combinational from `cnt`:
  - XID_scan_in[c] = xid_tbl[c][cnt].
  - YID_scan_in[c] = yid_tbl[c][cnt] when `cnt` < NUMS_PE_ROW, otherwise 0.
  - LN_config_in = ln_reg.
- Outside SCAN, or while `hold`=1, all `set_*` and scan data outputs are 0.
- Table writes are accepted only in IDLE or DONE:
  - A write takes effect on the edge it is sampled.
  - An out-of-range `xid_idx` (≥N) or `yid_idx` (≥NUMS_PE_ROW) is silently dropped.
  - A write while `busy`=1 is dropped and sets `wr_err`.
- `start` in SCAN or DONE is ignored (no restart, no counter reset).
- Simultaneous write and `start` in IDLE: the write is committed, and the scan begins with the new value.
- `hold` asserted in IDLE or DONE has no effect.

## Timing
- Reset (async, `rst`=0):
  - State is IDLE, `cnt`=0, mode_q=0.
  - All tables and ln_reg are 0.
  - `busy`, `done`, `wr_err` and all `set_*` / scan outputs are 0.
- Reset mid-scan aborts immediately with no `done` pulse. Tables are cleared as well.
- Latency:
  - `start` sampled at edge T gives the first `set_*` high in cycle T+1.
  - With no holds, the last scan cycle is T+L. `done`=1 in cycle T+L+1.
  - Each held cycle adds one cycle.
- `busy` is high in cycles T+1 through T+L (plus stalls). It is low in DONE.
- Back-to-back: `start` sampled in DONE is ignored. The earliest restart is a `start` sampled in the first IDLE cycle.

## Test plan
- Full scan, default params:
  - Stimulus: load xid_tbl[c][k] = (k+c)%16, yid_tbl[c][r] = r+c, ln = 5'b10101; pulse `start`.
  - Required: 48 `set_XID` cycles with `cnt` order 0..47, channel 1 cycle 0 = 1; `set_YID` only in cycles 0-5; `set_LN` only in cycle 0 with 5'b10101; `done` at T+49.
- YID-only mode:
  - Stimulus: `start` with `mode`=1.
  - Required: `set_XID` never asserts; 6 `set_YID` cycles; `done` at T+7.
- Hold:
  - Stimulus: assert `hold` for 3 cycles at `cnt`=10.
  - Required: `set_*`=0 for those 3 cycles; the scan resumes at `cnt`=10; `done` at T+52.
- Illegal writes:
  - Stimulus: xid write during SCAN; `xid_idx`=48 write in IDLE; `start` pulse mid-scan.
  - Required: table unchanged; `wr_err`=1 until the next `start`; scan length unaffected.
- Reset mid-scan:
  - Stimulus: drive `rst`=0 at `cnt`=20.
  - Required: all outputs 0 immediately, no `done` pulse; tables read back as 0 on the next scan.
- Parameter sweep:
  - Stimulus: NUMS_PE_ROW=4, NUMS_PE_COL=4, NUM_CH=2.
  - Required: 16-cycle full scan; correct channel bit slicing on XID_scan_in and YID_scan_in.
